// File: rtl/keypad_emulator_pkg.sv
// keypad_emulator_pkg: shared geometry, key range, FSM encoding and key decode helpers
package keypad_emulator_pkg;
    localparam int NUM_ROWS = 3;
    localparam int NUM_COLS = 3;
    localparam logic [3:0] KEY_MIN = 4'd1;
    localparam logic [3:0] KEY_MAX = 4'd9;
    typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, RELEASE = 2'd2} state_t;
    function automatic logic [1:0] key_row(input logic [3:0] code);
        logic [3:0] k;
        k = code - KEY_MIN;
        return 2'(k / 4'd3);
    endfunction
    function automatic logic [1:0] key_col(input logic [3:0] code);
        logic [3:0] k;
        k = code - KEY_MIN;
        return 2'(k % 4'd3);
    endfunction
endpackage

// File: rtl/keypad_emulator_row_sync_edge.sv
// row_sync_edge: 2-flop synchronizer for one active-low row strobe plus rise/fall pulses
// Ports: hwclk, rst (async, active-high) | row_n (async pin) | sync (synchronized level), rise, fall (one-cycle pulses)
module row_sync_edge (
    input  logic hwclk,
    input  logic rst,
    input  logic row_n,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic meta, prev;
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= row_n;
            sync <= meta;
            prev <= sync;
        end
    end
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: responder side of a 3x3 row-scan keypad, pulls the target column low while its row is strobed
// Ports: hwclk, rst (async, active-high) | key_code/key_valid/key_ready press handshake
//        keypad_r1..r3 row strobes in (active-low) | keypad_c1..c3 columns out (active-low)
//        busy (press or release gap running) | err (one-cycle pulse: bad code or timeout)
// Option: KEYPAD_EMU_BOUNCE_EN adds a contact-bounce burst at the start of every press
module keypad_emulator
    import keypad_emulator_pkg::*;
#(
    parameter int HOLD_SCANS     = 3,
    parameter int RELEASE_SCANS  = 2,
    parameter int TIMEOUT_CYCLES = 1000000
`ifdef KEYPAD_EMU_BOUNCE_EN
    ,
    parameter int BOUNCE_CYCLES  = 2000,
    parameter int BOUNCE_TOGGLE  = 250
`endif
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       keypad_r1,
    input  logic       keypad_r2,
    input  logic       keypad_r3,
    output logic       keypad_c1,
    output logic       keypad_c2,
    output logic       keypad_c3,
    output logic       busy,
    output logic       err
);
    localparam int SCAN_MAX = HOLD_SCANS > RELEASE_SCANS ? HOLD_SCANS : RELEASE_SCANS;
    localparam int SW = $clog2(SCAN_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] HOLD_N = SW'(HOLD_SCANS);
    localparam logic [SW-1:0] REL_N = SW'(RELEASE_SCANS);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t state, state_n;
    logic [1:0] row_q, col_q;
    logic [SW-1:0] scan_cnt;
    logic [TW-1:0] to_cnt;
    logic [NUM_COLS-1:0] cols;
    logic [NUM_ROWS-1:0] rows_n, sync, rise, fall;
    logic t_low, t_rise, t_fall, accept, code_ok, timeout, drive_en, col_drive;
    logic [3:0] sync_v, rise_v, fall_v;

    assign rows_n = {keypad_r3, keypad_r2, keypad_r1};

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
        row_sync_edge u_sync (
            .hwclk (hwclk),
            .rst   (rst),
            .row_n (rows_n[i]),
            .sync  (sync[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    // pad to 4 entries so a 2-bit row index never selects out of range
    assign sync_v = {1'b1, sync};
    assign rise_v = {1'b0, rise};
    assign fall_v = {1'b0, fall};
    assign t_low  = ~sync_v[row_q];
    assign t_rise = rise_v[row_q];
    assign t_fall = fall_v[row_q];

    assign key_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = key_valid & key_ready;
    assign code_ok   = key_code >= KEY_MIN && key_code <= KEY_MAX;
    assign timeout   = state != IDLE && !t_fall && to_cnt == TO_LAST;
    assign {keypad_c3, keypad_c2, keypad_c1} = cols;

    always_comb begin
        state_n = state == IDLE ? (accept && code_ok ? PRESS : IDLE) :
                  timeout ? IDLE :
                  state == PRESS ? (scan_cnt >= HOLD_N && t_rise ? RELEASE : PRESS) :
                  (scan_cnt == REL_N ? IDLE : RELEASE);
    end

    // gate on the next state too, so a timeout or release releases the column on the same edge
    assign col_drive = state == PRESS && state_n == PRESS && drive_en && t_low;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int BW = $clog2(BOUNCE_CYCLES + 1);
    localparam int GW = $clog2(BOUNCE_TOGGLE);
    localparam logic [BW-1:0] BNC_N = BW'(BOUNCE_CYCLES);
    localparam logic [GW-1:0] TOG_LAST = GW'(BOUNCE_TOGGLE - 1);
    logic [BW-1:0] bnc_cnt;
    logic [GW-1:0] tog_cnt;
    logic phase;
    // free-running burst timer from PRESS entry; phase 0 means drive allowed
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            bnc_cnt <= '0;
            tog_cnt <= '0;
            phase   <= 1'b0;
        end else if (accept && code_ok) begin
            bnc_cnt <= '0;
            tog_cnt <= '0;
            phase   <= 1'b0;
        end else if (state == PRESS && bnc_cnt != BNC_N) begin
            bnc_cnt <= bnc_cnt + BW'(1);
            tog_cnt <= tog_cnt == TOG_LAST ? '0 : tog_cnt + GW'(1);
            phase   <= phase ^ (tog_cnt == TOG_LAST);
        end
    end
    assign drive_en = bnc_cnt == BNC_N || !phase;
`else
    assign drive_en = 1'b1;
`endif

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            scan_cnt <= '0;
            to_cnt   <= '0;
            cols     <= '1;
            err      <= 1'b0;
        end else begin
            state <= state_n;
            err   <= (accept && !code_ok) || timeout;
            cols  <= ~({2'b00, col_drive} << col_q);
            if (accept && code_ok) begin
                row_q    <= key_row(key_code);
                col_q    <= key_col(key_code);
                scan_cnt <= '0;
                to_cnt   <= '0;
            end else if (state_n != state) begin
                scan_cnt <= '0;
                to_cnt   <= '0;
            end else if (state != IDLE) begin
                scan_cnt <= scan_cnt + SW'(t_fall);
                to_cnt   <= t_fall ? '0 : to_cnt + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: randomized self-checking bench with a row scanner and a window-level press model
module tb_keypad_emulator;
    localparam int HOLD = 3;
    localparam int REL  = 2;
    localparam int WIN  = 100;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int TMO = 5000;
`else
    localparam int TMO = 500;
`endif

    logic hwclk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] key_code = 4'd0;
    logic key_valid = 1'b0;
    logic [2:0] rows = 3'b111;
    logic key_ready, c1, c2, c3, busy, err;
    logic scan_en = 1'b0;
    logic [2:0] idle_rows = 3'b111;
    int ph_idx = 0;
    int ph_cnt = 0;
    logic [2:0] h0 = 3'b111, h1 = 3'b111, h2 = 3'b111;
    int checks = 0;
    int errors = 0;

    keypad_emulator #(
        .HOLD_SCANS     (HOLD),
        .RELEASE_SCANS  (REL),
        .TIMEOUT_CYCLES (TMO)
`ifdef KEYPAD_EMU_BOUNCE_EN
        ,
        .BOUNCE_CYCLES  (1000),
        .BOUNCE_TOGGLE  (100)
`endif
    ) dut (
        .hwclk     (hwclk),
        .rst       (rst),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .keypad_r1 (rows[0]),
        .keypad_r2 (rows[1]),
        .keypad_r3 (rows[2]),
        .keypad_c1 (c1),
        .keypad_c2 (c2),
        .keypad_c3 (c3),
        .busy      (busy),
        .err       (err)
    );

    always #5 hwclk = ~hwclk;

    // row pins as seen three clocks ago: the column must mirror h2 for the target row
    always @(posedge hwclk) begin
        h0 <= rows;
        h1 <= h0;
        h2 <= h1;
    end

    initial forever begin
        @(negedge hwclk);
        if (scan_en) begin
            rows = ph_idx == 0 ? 3'b110 : ph_idx == 1 ? 3'b101 : 3'b011;
            ph_cnt++;
            if (ph_cnt == WIN) begin
                ph_cnt = 0;
                ph_idx = ph_idx == 2 ? 0 : ph_idx + 1;
            end
        end else
            rows = idle_rows;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic align(input int row);
        int n = 0;
        do begin
            @(negedge hwclk);
            #1;
            n++;
        end while (!(ph_idx != row && ph_cnt >= 5 && ph_cnt <= 80 && key_ready) && n < 2000);
        check("align_ready", key_ready, 1);
    endtask

    task automatic send(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        @(posedge hwclk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic monitor(input int k);
        int row = (k - 1) / 3;
        int col = (k - 1) % 3;
        int n = 0, windows = 0, lowcnt = 0, illegal = 0, gap = 0, errs = 0;
        logic prev_tl = 1'b0;
        logic prev_d = h2[row];
        logic tl, d;
        logic [2:0] c;
        while (n < 3000) begin
            @(negedge hwclk);
            #1;
            n++;
            c = {c3, c2, c1};
            d = h2[row];
            for (int j = 0; j < 3; j++)
                if (!c[j] && !(j == col && !d)) illegal++;
            tl = !c[col];
            if (tl) lowcnt++;
            if (tl && !prev_tl) windows++;
            if (!tl && prev_tl) gap = 0;
            if (prev_d && !d) gap++;
            errs += int'(err);
            prev_tl = tl;
            prev_d = d;
            if (key_ready) break;
        end
        check($sformatf("k%0d_done", k), key_ready, 1);
        check($sformatf("k%0d_windows", k), windows, HOLD);
        check($sformatf("k%0d_low_cycles", k), lowcnt, HOLD * WIN);
        check($sformatf("k%0d_illegal", k), illegal, 0);
        check($sformatf("k%0d_gap_scans", k), gap, REL);
        check($sformatf("k%0d_err", k), errs, 0);
    endtask

    task automatic bad(input logic [3:0] k);
        @(negedge hwclk);
        #1;
        check("bad_ready", key_ready, 1);
        send(k);
        check($sformatf("bad%0d_err", k), err, 1);
        check($sformatf("bad%0d_busy", k), busy, 0);
        check($sformatf("bad%0d_cols", k), {c3, c2, c1}, 3'b111);
        @(posedge hwclk);
        #1;
        check($sformatf("bad%0d_err_once", k), err, 0);
        check($sformatf("bad%0d_cols2", k), {c3, c2, c1}, 3'b111);
    endtask

    initial begin
        int n, bcnt, r;
        logic [3:0] k;
        logic e;
        repeat (3) @(negedge hwclk);
        #1;
        check("rst_ready", key_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_cols", {c3, c2, c1}, 3'b111);
        rst = 1'b0;
        scan_en = 1'b1;
        repeat (20) @(negedge hwclk);
        bad(4'd0);
        bad(4'd12);
        repeat (3) begin
            r = $urandom_range(0, 6);
            bad(r == 0 ? 4'd0 : 4'(r + 9));
        end
`ifndef KEYPAD_EMU_BOUNCE_EN
        align(1);
        send(4'd5);
        monitor(5);
        repeat (6) begin
            k = 4'($urandom_range(1, 9));
            align((int'(k) - 1) / 3);
            send(k);
            monitor(int'(k));
        end
        align(0);
        send(4'd3);
        key_code  = 4'd7;
        key_valid = 1'b1;
        monitor(3);
        @(posedge hwclk);
        #1;
        key_valid = 1'b0;
        check("b2b_accept", busy, 1);
        monitor(7);
`endif
        align(0);
        send(4'd1);
        n = 0;
        while (c1 !== 1'b0 && n < 400) begin
            @(negedge hwclk);
            #1;
            n++;
        end
        check("midpress_c1_low", c1, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_c1", c1, 1);
        check("rst_async_busy", busy, 0);
        @(negedge hwclk);
        rst = 1'b0;
        @(posedge hwclk);
        #1;
        check("post_rst_ready", key_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_cols", {c3, c2, c1}, 3'b111);
        scan_en = 1'b0;
        repeat (10) @(negedge hwclk);
        #1;
        send(4'd9);
        n = 0;
        while (!err && n < TMO + 50) begin
            @(posedge hwclk);
            #1;
            n++;
        end
        check("tmo_cycles", n, TMO);
        check("tmo_busy", busy, 0);
        check("tmo_c3", c3, 1);
        check("tmo_ready", key_ready, 1);
        @(posedge hwclk);
        #1;
        check("tmo_err_once", err, 0);
`ifdef KEYPAD_EMU_BOUNCE_EN
        idle_rows = 3'b110;
        repeat (10) @(negedge hwclk);
        #1;
        send(4'd1);
        bcnt = 0;
        for (int i = 1; i <= 1300; i++) begin
            @(posedge hwclk);
            #1;
            e = i <= 1000 && ((i - 1) / 100) % 2 == 1;
            if (c1 !== e) bcnt++;
            if ({c3, c2} !== 2'b11) bcnt++;
        end
        check("bounce_pattern", bcnt, 0);
        check("bounce_busy", busy, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
